mem_arb_rr_n: RTL and testbench
===============================

Name: mem_arb_rr_n

Overview:
- Parametrised N-way arbiter. It multiplexes NREQ memory requesters onto a single memory master port.
- Successor to the fixed 4-way, 64-bit arbiter. Adds configurable requester count and widths, a selectable round-robin or fixed-priority mode, request-withdrawal handling, a grant-timeout watchdog, and status outputs.
- Sits between the cache/DMA requesters and the memory controller.

Parameters:
- NREQ, 4, number of requesters (2..16).
- AW, 64, address width.
- DW, 64, data width.
- MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
- TIMEOUT, 0, maximum GRANT cycles without rdy_m before forced release; 0 disables the watchdog.
- IW, $clog2(NREQ), grant index width (derived).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- addr_a  in  NREQ*AW  requester addresses; requester i owns slice [i*AW +: AW].
- dout_a  in  NREQ*DW  requester write data; slice [i*DW +: DW].
- din_a  out  NREQ*DW  read data; din_m broadcast to every slice.
- req_a  in  NREQ  request, one per requester.
- wr_a  in  NREQ  1 = write, 0 = read, per requester.
- rdy_a  out  NREQ  completion strobe, one per requester.
- addr_m  out  AW  address to memory.
- dout_m  out  DW  write data to memory.
- din_m  in  DW  read data from memory.
- req_m  out  1  memory request.
- wr_m  out  1  memory write enable.
- rdy_m  in  1  memory completion.
- gnt_idx  out  IW  index of the current or last granted requester.
- busy  out  1  high while in GRANT.
- timeout_err  out  1  one-cycle pulse on watchdog release.

Behaviour:
- State machine has two states, IDLE and GRANT. Registers: state, cur (IW bits), last (IW bits), wcnt (watchdog counter), timeout_err.
- Reset values: state = IDLE, cur = 0, last = NREQ-1 (so requester 0 wins first in round-robin), wcnt = 0, timeout_err = 0.
  - Outputs at reset: req_m = 0, wr_m = 0, rdy_a = 0, busy = 0, gnt_idx = 0.
  - addr_m and dout_m show slice 0.
- IDLE:
  - If any req_a bit is set, select a winner, register it into cur, go to GRANT next cycle, and clear wcnt.
  - Round-robin: scan indices last+1, last+2, ... modulo NREQ; the first set bit wins. The modulo wraps correctly for non-power-of-2 NREQ.
  - Fixed priority: the lowest set index wins; last is still updated but ignored.
  - With no requests, stay in IDLE.
- GRANT (combinational datapath):
  - req_m = req_a[cur], wr_m = wr_a[cur].
  - addr_m and dout_m = slice cur.
  - rdy_a[cur] = rdy_m; all other rdy_a bits are 0.
- In IDLE, req_m, wr_m and rdy_a are forced to 0; addr_m and dout_m keep muxing slice cur.
- GRANT exits, in priority order:
  1. rdy_m = 1: last <= cur, go to IDLE. The transfer is complete.
  2. req_a[cur] = 0 (withdrawn): last <= cur, go to IDLE. No rdy_a is issued, no error.
  3. TIMEOUT != 0 and wcnt == TIMEOUT-1: last <= cur, go to IDLE, timeout_err <= 1 for exactly one cycle.
  4. Otherwise wcnt increments, saturating at TIMEOUT-1.
- If rdy_m and the timeout condition coincide, rdy_m wins and no error is raised.
- Latency:
  - A request sampled in IDLE at cycle t gives req_m high at cycle t+1.
  - rdy_a is combinational from rdy_m in the same cycle.
  - After completion there is one mandatory IDLE cycle, so the minimum period per transfer is 2 cycles.
- gnt_idx = cur at all times. busy = (state == GRANT).
- reset asserted mid-GRANT: the next cycle is IDLE with all reset values; the in-flight transfer is dropped with no rdy_a.
- Requesters must hold req, addr, dout and wr stable until their rdy_a.

Test Plan:
1. NREQ=4, MODE=0; after reset, req_a = 4'b1111 held, rdy_m returned one cycle after each req_m -> grant order 0,1,2,3,0; one IDLE cycle between grants; rdy_a pulses 0001, 0010, 0100, 1000.
2. MODE=1; req_a = 4'b1010 held, immediate rdy_m -> gnt_idx is always 1; requester 3 is never granted while bit 1 stays set.
3. NREQ=3 (non-power-of-2), MODE=0; last = 2, req_a = 3'b101 -> requester 0 is granted (wrap), then requester 2; index 3 never appears.
4. TIMEOUT=4; grant requester 2 with rdy_m held 0 -> after 4 GRANT cycles the FSM returns to IDLE, timeout_err is high for exactly 1 cycle, rdy_a stays 0, and the next grant goes to requester 3 if it is requesting.
5. Requester 1 granted, then req_a[1] dropped before rdy_m -> IDLE next cycle, no rdy_a, no timeout_err, last = 1.
6. reset asserted in the second GRANT cycle with addr_a slice = 0xDEAD -> next cycle busy = 0, req_m = 0, gnt_idx = 0; after release, requester 0 is served first.

Source files
------------

// File: rtl/mem_arb_rr_n.sv
// mem_arb_rr_n: N-way arbiter that multiplexes NREQ memory requesters onto
// a single memory master port. It supports round-robin or fixed-priority
// selection. A requester that drops its request before completion is
// released. An optional watchdog forces release of a grant that never
// completes and reports it with a one-cycle error pulse.
module mem_arb_rr_n #(
    parameter int NREQ    = 4,
    parameter int AW      = 64,
    parameter int DW      = 64,
    parameter int MODE    = 0,
    parameter int TIMEOUT = 0,
    parameter int IW      = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ*AW-1:0]   addr_a,
    input  logic [NREQ*DW-1:0]   dout_a,
    output logic [NREQ*DW-1:0]   din_a,
    input  logic [NREQ-1:0]      req_a,
    input  logic [NREQ-1:0]      wr_a,
    output logic [NREQ-1:0]      rdy_a,
    output logic [AW-1:0]        addr_m,
    output logic [DW-1:0]        dout_m,
    input  logic [DW-1:0]        din_m,
    output logic                 req_m,
    output logic                 wr_m,
    input  logic                 rdy_m,
    output logic [IW-1:0]        gnt_idx,
    output logic                 busy,
    output logic                 timeout_err
);

    // The watchdog counter needs at least one bit, even when it is disabled.
    localparam int             WCW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0] WLIM     = WCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IW-1:0]  LAST_RST = IW'(NREQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state_reg;
    logic [IW-1:0]  cur_reg;
    logic [IW-1:0]  last_reg;
    logic [WCW-1:0] wcnt_reg;
    logic           timeout_err_reg;

    logic [AW-1:0]  addr_arr [NREQ];
    logic [DW-1:0]  dout_arr [NREQ];
    logic [IW-1:0]  win_idx;
    logic           any_req;
    logic           sel_req;
    logic           sel_wr;
    logic           in_grant;
    int             rr_pos;

    // Unpack the requester buses, broadcast the read data and steer completions.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign addr_arr[gi]           = addr_a[gi*AW +: AW];
            assign dout_arr[gi]           = dout_a[gi*DW +: DW];
            assign din_a[gi*DW +: DW]     = din_m;
            assign rdy_a[gi]              = in_grant && (cur_reg == IW'(gi)) && rdy_m;
        end
    endgenerate

    assign any_req  = |req_a;
    assign in_grant = (state_reg == GRANT);
    assign sel_req  = req_a[cur_reg];
    assign sel_wr   = wr_a[cur_reg];

    assign req_m       = in_grant & sel_req;
    assign wr_m        = in_grant & sel_wr;
    assign addr_m      = addr_arr[cur_reg];
    assign dout_m      = dout_arr[cur_reg];
    assign gnt_idx     = cur_reg;
    assign busy        = in_grant;
    assign timeout_err = timeout_err_reg;

    // Pick the winner among the current requests.
    // The loops scan from the far end so the earliest candidate is assigned last and wins.
    always_comb begin
        win_idx = '0;
        rr_pos  = 0;
        if (MODE == 1) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (req_a[IW'(k)]) win_idx = IW'(k);
            end
        end else begin
            for (int k = NREQ; k >= 1; k--) begin
                rr_pos = (int'(last_reg) + k) % NREQ;
                if (req_a[IW'(rr_pos)]) win_idx = IW'(rr_pos);
            end
        end
    end

    // Arbitration FSM: issue a grant from IDLE and release it on completion, withdrawal or watchdog expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            cur_reg         <= '0;
            last_reg        <= LAST_RST;
            wcnt_reg        <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            timeout_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        cur_reg   <= win_idx;
                        wcnt_reg  <= '0;
                        state_reg <= GRANT;
                    end
                end
                GRANT: begin
                    if (rdy_m || !sel_req) begin
                        last_reg  <= cur_reg;
                        state_reg <= IDLE;
                    end else if ((TIMEOUT != 0) && (wcnt_reg == WLIM)) begin
                        last_reg        <= cur_reg;
                        state_reg       <= IDLE;
                        timeout_err_reg <= 1'b1;
                    end else if (wcnt_reg != WLIM) begin
                        wcnt_reg <= wcnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arb_rr_n.sv
// Bench for mem_arb_rr_n. Three instances: 4-way round-robin with watchdog,
// 3-way round-robin, and 4-way fixed priority. Each one is checked against
// a behavioural model of the arbitration rules, plus directed sequences.
`timescale 1ns/1ps
module tb_mem_arb_rr_n;
    localparam int AW = 16;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // instance 0: NREQ=4, round-robin, TIMEOUT=4
    logic [4*AW-1:0] addr_a0;
    logic [4*DW-1:0] dout_a0, din_a0;
    logic [3:0]      req_a0, wr_a0, rdy_a0;
    logic [AW-1:0]   addr_m0;
    logic [DW-1:0]   dout_m0, din_m0;
    logic            req_m0, wr_m0, rdy_m0, busy0, terr0;
    logic [1:0]      gnt0;
    // instance 1: NREQ=3, round-robin, no watchdog
    logic [3*AW-1:0] addr_a1;
    logic [3*DW-1:0] dout_a1, din_a1;
    logic [2:0]      req_a1, wr_a1, rdy_a1;
    logic [AW-1:0]   addr_m1;
    logic [DW-1:0]   dout_m1, din_m1;
    logic            req_m1, wr_m1, rdy_m1, busy1, terr1;
    logic [1:0]      gnt1;
    // instance 2: NREQ=4, fixed priority, no watchdog
    logic [4*AW-1:0] addr_a2;
    logic [4*DW-1:0] dout_a2, din_a2;
    logic [3:0]      req_a2, wr_a2, rdy_a2;
    logic [AW-1:0]   addr_m2;
    logic [DW-1:0]   dout_m2, din_m2;
    logic            req_m2, wr_m2, rdy_m2, busy2, terr2;
    logic [1:0]      gnt2;

    mem_arb_rr_n #(.NREQ(4), .AW(AW), .DW(DW), .MODE(0), .TIMEOUT(4)) u0 (
        .clk(clk), .reset(reset), .addr_a(addr_a0), .dout_a(dout_a0), .din_a(din_a0),
        .req_a(req_a0), .wr_a(wr_a0), .rdy_a(rdy_a0), .addr_m(addr_m0), .dout_m(dout_m0),
        .din_m(din_m0), .req_m(req_m0), .wr_m(wr_m0), .rdy_m(rdy_m0), .gnt_idx(gnt0),
        .busy(busy0), .timeout_err(terr0));

    mem_arb_rr_n #(.NREQ(3), .AW(AW), .DW(DW), .MODE(0), .TIMEOUT(0)) u1 (
        .clk(clk), .reset(reset), .addr_a(addr_a1), .dout_a(dout_a1), .din_a(din_a1),
        .req_a(req_a1), .wr_a(wr_a1), .rdy_a(rdy_a1), .addr_m(addr_m1), .dout_m(dout_m1),
        .din_m(din_m1), .req_m(req_m1), .wr_m(wr_m1), .rdy_m(rdy_m1), .gnt_idx(gnt1),
        .busy(busy1), .timeout_err(terr1));

    mem_arb_rr_n #(.NREQ(4), .AW(AW), .DW(DW), .MODE(1), .TIMEOUT(0)) u2 (
        .clk(clk), .reset(reset), .addr_a(addr_a2), .dout_a(dout_a2), .din_a(din_a2),
        .req_a(req_a2), .wr_a(wr_a2), .rdy_a(rdy_a2), .addr_m(addr_m2), .dout_m(dout_m2),
        .din_m(din_m2), .req_m(req_m2), .wr_m(wr_m2), .rdy_m(rdy_m2), .gnt_idx(gnt2),
        .busy(busy2), .timeout_err(terr2));

    // per-instance configuration and stimulus
    int          p_n    [3] = '{4, 3, 4};
    int          p_mode [3] = '{0, 0, 1};
    int          p_to   [3] = '{4, 0, 0};
    logic [3:0]  s_req  [3];
    logic [3:0]  s_wr   [3];
    logic        s_rdy  [3];
    logic [15:0] s_addr [3][4];
    logic [15:0] s_dout [3][4];
    logic [15:0] s_din  [3];

    // reference model: who owns the memory port, for how long, and who was served last
    bit m_busy [3];
    int m_cur  [3];
    int m_last [3];
    int m_age  [3];
    bit m_terr [3];
    bit model_on;

    int n_vec;
    int n_err;

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic       busy;
        logic [1:0] gnt;
        logic       req_m;
        logic [3:0] rdy_a;
    } vec_t;
    vec_t tbl [16];

    int exp_t3_gnt  [3] = '{0, 2, 0};
    int exp_t3_rdya [3] = '{1, 4, 1};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            addr_a0[i*AW +: AW] = s_addr[0][i];
            dout_a0[i*DW +: DW] = s_dout[0][i];
            addr_a2[i*AW +: AW] = s_addr[2][i];
            dout_a2[i*DW +: DW] = s_dout[2][i];
        end
        for (int i = 0; i < 3; i++) begin
            addr_a1[i*AW +: AW] = s_addr[1][i];
            dout_a1[i*DW +: DW] = s_dout[1][i];
        end
        req_a0 = s_req[0];      wr_a0 = s_wr[0];      rdy_m0 = s_rdy[0]; din_m0 = s_din[0];
        req_a1 = s_req[1][2:0]; wr_a1 = s_wr[1][2:0]; rdy_m1 = s_rdy[1]; din_m1 = s_din[1];
        req_a2 = s_req[2];      wr_a2 = s_wr[2];      rdy_m2 = s_rdy[2]; din_m2 = s_din[2];
    endtask

    function automatic int pick(input int d);
        if (p_mode[d] == 1) begin
            for (int i = 0; i < p_n[d]; i++) if (s_req[d][i]) return i;
        end else begin
            for (int k = 1; k <= p_n[d]; k++) begin
                int i;
                i = (m_last[d] + k) % p_n[d];
                if (s_req[d][i]) return i;
            end
        end
        return 0;
    endfunction

    task automatic model_check();
        for (int d = 0; d < 3; d++) begin
            logic        a_busy, a_reqm, a_wrm, a_terr;
            logic [1:0]  a_gnt;
            logic [3:0]  a_rdy, e_rdy;
            logic [15:0] a_addr, a_dout;
            logic [63:0] a_din;
            case (d)
                0: begin a_busy = busy0; a_gnt = gnt0; a_reqm = req_m0; a_wrm = wr_m0; a_terr = terr0;
                         a_rdy = rdy_a0; a_addr = addr_m0; a_dout = dout_m0; a_din = din_a0; end
                1: begin a_busy = busy1; a_gnt = gnt1; a_reqm = req_m1; a_wrm = wr_m1; a_terr = terr1;
                         a_rdy = {1'b0, rdy_a1}; a_addr = addr_m1; a_dout = dout_m1; a_din = {16'h0, din_a1}; end
                default: begin a_busy = busy2; a_gnt = gnt2; a_reqm = req_m2; a_wrm = wr_m2; a_terr = terr2;
                         a_rdy = rdy_a2; a_addr = addr_m2; a_dout = dout_m2; a_din = din_a2; end
            endcase
            e_rdy = (m_busy[d] && s_rdy[d]) ? (4'b0001 << m_cur[d]) : 4'b0000;
            chk($sformatf("d%0d busy", d), a_busy, m_busy[d]);
            chk($sformatf("d%0d gnt_idx", d), a_gnt, m_cur[d]);
            chk($sformatf("d%0d req_m", d), a_reqm, m_busy[d] && s_req[d][m_cur[d]]);
            chk($sformatf("d%0d wr_m", d), a_wrm, m_busy[d] && s_wr[d][m_cur[d]]);
            chk($sformatf("d%0d rdy_a", d), a_rdy, e_rdy);
            chk($sformatf("d%0d addr_m", d), a_addr, s_addr[d][m_cur[d]]);
            chk($sformatf("d%0d dout_m", d), a_dout, s_dout[d][m_cur[d]]);
            chk($sformatf("d%0d timeout_err", d), a_terr, m_terr[d]);
            for (int i = 0; i < p_n[d]; i++)
                chk($sformatf("d%0d din_a[%0d]", d, i), a_din[i*16 +: 16], s_din[d]);
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 3; d++) begin
            if (reset) begin
                m_busy[d] = 0; m_cur[d] = 0; m_last[d] = p_n[d] - 1; m_age[d] = 0; m_terr[d] = 0;
            end else begin
                bit t;
                t = 0;
                if (!m_busy[d]) begin
                    if (s_req[d] != 0) begin
                        m_cur[d] = pick(d); m_busy[d] = 1; m_age[d] = 0;
                    end
                end else if (s_rdy[d] || !s_req[d][m_cur[d]]) begin
                    m_last[d] = m_cur[d]; m_busy[d] = 0;
                end else if (p_to[d] != 0 && m_age[d] == p_to[d] - 1) begin
                    m_last[d] = m_cur[d]; m_busy[d] = 0; t = 1;
                end else if (m_age[d] < p_to[d] - 1) begin
                    m_age[d]++;
                end
                m_terr[d] = t;
            end
        end
    endtask

    // drive the cycle's inputs and move to the sampling point
    task automatic apply();
        drive();
        @(negedge clk);
    endtask

    // compare against the model, let the DUT clock, and land just after the edge
    task automatic advance();
        if (model_on) model_check();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0; n_err = 0; model_on = 0; reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            s_req[d] = '0; s_wr[d] = '0; s_rdy[d] = 1'b0; s_din[d] = 16'h5A00 + 16'(d);
            for (int i = 0; i < 4; i++) begin
                s_addr[d][i] = 16'h1000 + 16'(d*16 + i);
                s_dout[d][i] = 16'h2000 + 16'(d*16 + i);
            end
        end
        apply(); advance();
        apply(); advance();
        reset = 1'b0;
        model_on = 1;

        // reset values
        apply();
        chk("rst busy", busy0, 1'b0);
        chk("rst req_m", req_m0, 1'b0);
        chk("rst wr_m", wr_m0, 1'b0);
        chk("rst rdy_a", rdy_a0, 4'b0);
        chk("rst gnt_idx", gnt0, 2'd0);
        chk("rst timeout_err", terr0, 1'b0);
        chk("rst addr_m slice0", addr_m0, 16'h1000);
        chk("rst dout_m slice0", dout_m0, 16'h2000);
        advance();

        // round-robin over four held requests, completion one cycle after req_m
        tbl[0]  = '{4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[1]  = '{4'b1111, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000};
        tbl[2]  = '{4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001};
        tbl[3]  = '{4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[4]  = '{4'b1111, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0000};
        tbl[5]  = '{4'b1111, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010};
        tbl[6]  = '{4'b1111, 1'b0, 1'b0, 2'd1, 1'b0, 4'b0000};
        tbl[7]  = '{4'b1111, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0000};
        tbl[8]  = '{4'b1111, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100};
        tbl[9]  = '{4'b1111, 1'b0, 1'b0, 2'd2, 1'b0, 4'b0000};
        tbl[10] = '{4'b1111, 1'b0, 1'b1, 2'd3, 1'b1, 4'b0000};
        tbl[11] = '{4'b1111, 1'b1, 1'b1, 2'd3, 1'b1, 4'b1000};
        tbl[12] = '{4'b1111, 1'b0, 1'b0, 2'd3, 1'b0, 4'b0000};
        tbl[13] = '{4'b1111, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000};
        tbl[14] = '{4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001};
        tbl[15] = '{4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
        for (int r = 0; r < 16; r++) begin
            s_req[0] = tbl[r].req; s_rdy[0] = tbl[r].rdy;
            apply();
            chk($sformatf("rr row%0d busy", r), busy0, tbl[r].busy);
            chk($sformatf("rr row%0d gnt_idx", r), gnt0, tbl[r].gnt);
            chk($sformatf("rr row%0d req_m", r), req_m0, tbl[r].req_m);
            chk($sformatf("rr row%0d rdy_a", r), rdy_a0, tbl[r].rdy_a);
            advance();
        end

        // fixed priority: requester 1 always beats requester 3
        s_req[2] = 4'b1010; s_rdy[2] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            apply();
            if (c % 2 == 1) begin
                chk("fp busy", busy2, 1'b1);
                chk("fp gnt_idx", gnt2, 2'd1);
                chk("fp rdy_a", rdy_a2, 4'b0010);
            end else begin
                chk("fp idle", busy2, 1'b0);
            end
            advance();
        end
        s_req[2] = '0; s_rdy[2] = 1'b0;

        // three requesters: wrap from 2 back to 0
        s_req[1] = 4'b0101; s_rdy[1] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            apply();
            if (c % 2 == 1) begin
                chk("nreq3 gnt_idx", gnt1, exp_t3_gnt[c/2]);
                chk("nreq3 rdy_a", rdy_a1, exp_t3_rdya[c/2]);
            end
            advance();
        end
        s_req[1] = '0; s_rdy[1] = 1'b0;

        // watchdog: requester 2 never completes, requester 3 queued behind it
        s_req[0] = 4'b0100; s_rdy[0] = 1'b0;
        apply(); chk("wd idle", busy0, 1'b0); advance();
        s_req[0] = 4'b1100;
        for (int c = 0; c < 4; c++) begin
            apply();
            chk("wd grant busy", busy0, 1'b1);
            chk("wd grant gnt_idx", gnt0, 2'd2);
            chk("wd grant rdy_a", rdy_a0, 4'b0);
            chk("wd grant timeout_err", terr0, 1'b0);
            advance();
        end
        apply();
        chk("wd release busy", busy0, 1'b0);
        chk("wd release timeout_err", terr0, 1'b1);
        chk("wd release rdy_a", rdy_a0, 4'b0);
        advance();
        s_rdy[0] = 1'b1;
        apply();
        chk("wd next gnt_idx", gnt0, 2'd3);
        chk("wd next timeout_err", terr0, 1'b0);
        chk("wd next rdy_a", rdy_a0, 4'b1000);
        advance();
        s_req[0] = '0; s_rdy[0] = 1'b0;
        apply(); advance();

        // withdrawal: requester 1 drops its request before completion
        s_req[0] = 4'b0010;
        apply(); advance();
        apply();
        chk("wdr grant gnt_idx", gnt0, 2'd1);
        chk("wdr grant req_m", req_m0, 1'b1);
        advance();
        s_req[0] = 4'b0000;
        apply();
        chk("wdr drop req_m", req_m0, 1'b0);
        chk("wdr drop rdy_a", rdy_a0, 4'b0);
        advance();
        s_req[0] = 4'b1111;
        apply();
        chk("wdr idle busy", busy0, 1'b0);
        chk("wdr idle timeout_err", terr0, 1'b0);
        chk("wdr idle rdy_a", rdy_a0, 4'b0);
        advance();
        s_rdy[0] = 1'b1;
        apply();
        chk("wdr next gnt_idx", gnt0, 2'd2);
        advance();
        s_req[0] = '0; s_rdy[0] = 1'b0;
        apply(); advance();

        // reset during the second GRANT cycle
        s_addr[0][2] = 16'hDEAD; s_req[0] = 4'b0100;
        apply(); advance();
        apply();
        chk("rstg addr_m", addr_m0, 16'hDEAD);
        chk("rstg busy", busy0, 1'b1);
        advance();
        reset = 1'b1;
        apply(); advance();
        reset = 1'b0; s_req[0] = 4'b1111;
        apply();
        chk("rstg after busy", busy0, 1'b0);
        chk("rstg after req_m", req_m0, 1'b0);
        chk("rstg after gnt_idx", gnt0, 2'd0);
        chk("rstg after rdy_a", rdy_a0, 4'b0);
        advance();
        s_rdy[0] = 1'b1;
        apply();
        chk("rstg first gnt_idx", gnt0, 2'd0);
        chk("rstg first rdy_a", rdy_a0, 4'b0001);
        advance();
        s_req[0] = '0; s_rdy[0] = 1'b0;
        apply(); advance();

        // randomized traffic on all three instances against the model
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 3; d++) begin
                for (int i = 0; i < p_n[d]; i++) begin
                    if ($urandom_range(7) == 0) s_req[d][i] = ~s_req[d][i];
                    s_wr[d][i]   = 1'($urandom);
                    s_addr[d][i] = 16'($urandom);
                    s_dout[d][i] = 16'($urandom);
                end
                s_rdy[d] = ($urandom_range(2) == 0);
                s_din[d] = 16'($urandom);
            end
            reset = ($urandom_range(299) == 0);
            apply();
            advance();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
